// File: rtl/block_read_sequencer_if.sv
// -----------------------------------------------------------------------------
// block_read_sequencer_if
// Bus bundle for the DCT block read sequencer.
//   Memory read side : rd_en, rd_addr (sequencer -> memory), rd_data (memory ->
//                      sequencer, valid one cycle after rd_en).
//   Sample stream    : out_data, out_valid, out_last (sequencer -> consumer),
//                      out_ready (consumer -> sequencer).
// Modports:
//   master - the sequencer.
//   slave  - the memory/consumer environment.
// -----------------------------------------------------------------------------
interface block_read_sequencer_if #(
  parameter int K      = 6,
  parameter int DATA_W = 16
) ();
  logic              rd_en;
  logic [K-1:0]      rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output rd_en, rd_addr, out_data, out_valid, out_last,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, out_data, out_valid, out_last,
    output rd_data, out_ready
  );
endinterface

// File: rtl/block_read_sequencer.sv
// -----------------------------------------------------------------------------
// block_read_sequencer
// Drains a 2^K-entry DCT block buffer once per start pulse. With TRANSPOSE=1
// the block is read column-major (address halves swapped), which is the order
// the second 1-D DCT pass consumes; TRANSPOSE=0 reads in raster order.
// Read data returns one cycle after rd_en and lands in a 2-entry output
// buffer that drives a valid/ready stream.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset, clears all state
//   start  in   block start pulse, honoured only when idle
//   busy   out  high from start acceptance until the block is done
//   done   out  one-cycle pulse after the final sample handshake
//   bus    master modport: rd_en/rd_addr/rd_data memory port,
//          out_data/out_valid/out_ready/out_last sample stream
// -----------------------------------------------------------------------------
module block_read_sequencer #(
  parameter int K         = 6,
  parameter int DATA_W    = 16,
  parameter int TRANSPOSE = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  block_read_sequencer_if.master bus
);

  localparam int HALF = K / 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [K-1:0]               r_idx;
  logic                       r_vld_p1;
  logic                       r_last_p1;
  logic [1:0][DATA_W-1:0]     r_buf_data;
  logic [1:0]                 r_buf_last;
  logic                       r_wptr;
  logic                       r_rptr;
  logic [1:0]                 r_count;

  logic                       w_valid;
  logic                       w_pop;
  logic                       w_last_idx;
  logic [2:0]                 w_occ;
  logic                       w_credit_ok;
  logic                       w_rd_en;

  // Column-major order is the raster index with its row/column halves swapped.
  function automatic logic [K-1:0] map_addr(input logic [K-1:0] idx);
    logic [K-1:0] addr;
    if (TRANSPOSE != 0) addr = {idx[HALF-1:0], idx[K-1:HALF]};
    else                addr = idx;
    return addr;
  endfunction

  assign w_valid    = (r_count != 2'd0);
  assign w_pop      = w_valid & bus.out_ready;
  assign w_last_idx = (r_idx == {K{1'b1}});

  // Slots committed = stored entries + the read returning next cycle, minus the
  // entry leaving this cycle. Keeping this below 2 before issuing guarantees
  // the 2-entry buffer can always absorb the returning word.
  assign w_occ       = {1'b0, r_count} + {2'b00, r_vld_p1} - {2'b00, w_pop};
  assign w_credit_ok = (w_occ < 3'd2);
  assign w_rd_en     = (r_state == S_RUN) && w_credit_ok;

  assign bus.rd_en     = w_rd_en;
  assign bus.rd_addr   = map_addr(r_idx);
  assign bus.out_valid = w_valid;
  assign bus.out_data  = r_buf_data[r_rptr];
  assign bus.out_last  = w_valid & r_buf_last[r_rptr];

  assign busy = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done = (r_state == S_DONE);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_rd_en && w_last_idx) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_pop && bus.out_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Stage p0: read issue. The counter wraps to 0 on the final issue so the
  // next block always begins at index 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx     <= '0;
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
    end else begin
      if (w_rd_en) begin
        r_idx <= w_last_idx ? '0 : r_idx + 1'b1;
      end
      r_vld_p1  <= w_rd_en;
      r_last_p1 <= w_rd_en & w_last_idx;
    end
  end

  // Stage p1: returning read data enters the output buffer with its last tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_data <= '0;
      r_buf_last <= '0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      if (r_vld_p1) begin
        r_buf_data[r_wptr] <= bus.rd_data;
        r_buf_last[r_wptr] <= r_last_p1;
        r_wptr             <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= r_count + {1'b0, r_vld_p1} - {1'b0, w_pop};
    end
  end

endmodule

// File: doc/block_read_sequencer.md
Name: block_read_sequencer

Overview:
Read-side sequencer for the DCT block buffer. The write side fills a 2^K-entry buffer in raster order using an up-counter. This block drains that buffer once per start pulse. With TRANSPOSE=1 it reads in column-major (transposed) order, which is what the second 1-D DCT pass consumes. Memory read data is forwarded through a 2-entry output buffer with valid/ready backpressure.

Parameters:
K, 6, buffer address width; block holds 2^K samples (K even; row length 2^(K/2)).
DATA_W, 16, sample width.
TRANSPOSE, 1, 1 = column-major read order, 0 = raster read order.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous, active-high; clears all state.
start  input  1  pulse; accepted only in IDLE.
rd_en  output  1  memory read strobe.
rd_addr  output  K  memory read address.
rd_data  input  DATA_W  memory data, valid exactly 1 cycle after rd_en.
out_data  output  DATA_W  sample to downstream.
out_valid  output  1  out_data valid.
out_ready  input  1  downstream accepts when high with out_valid.
out_last  output  1  high with the final sample of the block.
busy  output  1  high from start acceptance until done.
done  output  1  1-cycle pulse after final handshake.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. Reset has priority over every other input.
- Reset values: rd_en=0, rd_addr=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0. Issue counter, buffer, credits and state are all cleared. State goes to IDLE.
- States:
  - IDLE: start=1 moves to RUN and sets busy=1. start=0 stays in IDLE.
  - RUN: issues reads. After the read with index 2^K-1 is issued, moves to DRAIN.
  - DRAIN: waits until the final sample handshakes (out_valid & out_ready & out_last). That cycle moves to DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- start outside IDLE is ignored. No queuing.
- Issue counter i (K bits) increments on each rd_en.
  - TRANSPOSE=0: rd_addr = i.
  - TRANSPOSE=1: rd_addr = {i[K/2-1:0], i[K-1:K/2]}, i.e. low and high halves swapped.
- Credit rule: rd_en=1 in RUN only when (buffer occupancy + reads in flight) < 2, counting a pop in the same cycle. The 2-entry buffer therefore never overflows.
- Return path: rd_data is written into the buffer in the cycle after rd_en. out_data/out_valid come from the buffer head and are registered.
- Latency: start accepted in cycle 0 → first rd_en in cycle 1 → first out_valid in cycle 3.
- Throughput: with out_ready held high, one sample per cycle.
- While out_valid=1 and out_ready=0, out_data and out_last hold stable. No sample is dropped or duplicated.
- out_last is tagged on the entry read with i=2^K-1.
- Counter wrap: i returns to 0 when RUN exits. A new block always starts at i=0.
- Reset mid-operation: any in-flight read is discarded. Next cycle all outputs are at reset values.

Test Plan:
1. K=6, TRANSPOSE=1, memory word = address, out_ready=1, start in cycle 0 → out_data sequence 0,8,16,…,56,1,9,…,63 in cycles 3..66; out_last only on 63 (cycle 66); done=1 in cycle 67; busy high cycles 1..66.
2. TRANSPOSE=0, same stimulus → out_data 0,1,2,…,63 in order; out_last with 63.
3. out_ready=0 for 10 cycles after the first out_valid → at most 2 rd_en beyond the accepted count; out_data=0 held for all 10 cycles; on resume the sequence continues 8,16,… with no gaps or duplicates.
4. start pulsed again in cycles 5 and 40 of a running block → ignored; exactly 64 outputs and one done pulse. start in the cycle after done → new block starts from address 0.
5. reset asserted after the 20th handshake → next cycle out_valid=0, rd_en=0, busy=0, done=0. A new start produces the full 64-sample sequence from 0.
6. out_ready randomly toggled (50%) across 4 back-to-back blocks → each block delivers all 64 samples in the expected order, one out_last and one done per block.
